// File: rtl/rr_fifo_reader.sv
// Round-robin pop-side reader for four flow-controlled FIFOs.
// Forwards one word per cycle downstream with its source index.
module rr_fifo_reader #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    fifo_empty,
    input  logic [3:0]    fifo_valid,
    input  logic [3:0]    fifo_error,
    input  logic [DW-1:0] data_in0,
    input  logic [DW-1:0] data_in1,
    input  logic [DW-1:0] data_in2,
    input  logic [DW-1:0] data_in3,
    input  logic          pause_in,
    output logic [3:0]    pop,
    output logic [DW-1:0] data_out,
    output logic          push_out,
    output logic [1:0]    dest_out,
    output logic          error_out,
    output logic          idle_out,
    output logic [CW-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        PAUSE,
        ERROR
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    ptr_q;
    logic [1:0]    gnt_idx;
    logic [1:0]    cand;
    logic          gnt_any;
    logic          pop_any;
    logic          fault;
    logic          capture;
    logic [DW-1:0] sel_data;

    // Walk from lowest to highest priority so the closest-to-ptr
    // non-empty FIFO is the one left standing.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (!fifo_empty[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign pop_any = (state_q == ACTIVE) && !pause_in && gnt_any;
    assign pop     = pop_any ? (4'b0001 << gnt_idx) : 4'b0000;

    // pop ^ valid flags both a pop left unanswered and an unsolicited valid.
    assign fault   = (state_q != IDLE) &&
                     ((|fifo_error) || (|(pop ^ fifo_valid)));
    assign capture = pop_any && !fault;

    always_comb begin
        sel_data = data_in0;
        unique case (gnt_idx)
            2'd0: sel_data = data_in0;
            2'd1: sel_data = data_in1;
            2'd2: sel_data = data_in2;
            2'd3: sel_data = data_in3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   state_d = ACTIVE;
            ACTIVE: begin
                if (fault)
                    state_d = ERROR;
                else if (pause_in)
                    state_d = PAUSE;
            end
            PAUSE: begin
                if (fault)
                    state_d = ERROR;
                else if (!pause_in)
                    state_d = ACTIVE;
            end
            ERROR:  state_d = ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (pop_any)
                ptr_q <= gnt_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            dest_out   <= 2'd0;
            push_out   <= 1'b0;
            word_count <= '0;
        end else begin
            push_out <= capture;
            if (capture) begin
                data_out   <= sel_data;
                dest_out   <= gnt_idx;
                word_count <= word_count + CW'(1);
            end
        end
    end

    assign error_out = (state_q == ERROR);
    assign idle_out  = (state_q == ACTIVE) && (&fifo_empty);

endmodule

// File: tb/tb_rr_fifo_reader.sv
// Directed bench for rr_fifo_reader with valid looped back from pop.
module tb_rr_fifo_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fifo_empty;
    logic [3:0]  fifo_valid;
    logic [3:0]  fifo_error;
    logic [7:0]  data_in0, data_in1, data_in2, data_in3;
    logic        pause_in;
    logic [3:0]  pop;
    logic [7:0]  data_out;
    logic        push_out;
    logic [1:0]  dest_out;
    logic        error_out;
    logic        idle_out;
    logic [15:0] word_count;

    logic        vforce;
    logic [3:0]  vovr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign fifo_valid = vforce ? vovr : pop;

    rr_fifo_reader #(.DW(8), .CW(16)) dut (
        .clk(clk),
        .reset(reset),
        .fifo_empty(fifo_empty),
        .fifo_valid(fifo_valid),
        .fifo_error(fifo_error),
        .data_in0(data_in0),
        .data_in1(data_in1),
        .data_in2(data_in2),
        .data_in3(data_in3),
        .pause_in(pause_in),
        .pop(pop),
        .data_out(data_out),
        .push_out(push_out),
        .dest_out(dest_out),
        .error_out(error_out),
        .idle_out(idle_out),
        .word_count(word_count)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Leaves the DUT in IDLE; the next posedge starts ACTIVE cycle 0.
    task automatic do_reset();
        reset      = 1'b0;
        fifo_empty = 4'hF;
        fifo_error = 4'h0;
        pause_in   = 1'b0;
        vforce     = 1'b0;
        vovr       = 4'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    logic [3:0] exp_pop  [11];
    logic       exp_push [11];

    initial begin
        data_in0 = 8'hA0;
        data_in1 = 8'hA1;
        data_in2 = 8'hA2;
        data_in3 = 8'hA3;

        // Reset values
        reset      = 1'b0;
        fifo_empty = 4'h0;
        fifo_error = 4'h0;
        pause_in   = 1'b0;
        vforce     = 1'b0;
        vovr       = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pop", 32'(pop), 32'h0);
        chk("rst_push", 32'(push_out), 32'h0);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_dest", 32'(dest_out), 32'h0);
        chk("rst_wc", 32'(word_count), 32'h0);
        chk("rst_err", 32'(error_out), 32'h0);
        chk("rst_idle", 32'(idle_out), 32'h0);

        // Round robin: IDLE cycle has no pop
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("idle_pop", 32'(pop), 32'h0);
        @(posedge clk);
        #1;
        chk("rr_push0", 32'(push_out), 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("rr_pop", 32'(pop), 32'(4'b0001 << (i % 4)));
            @(posedge clk);
            #1;
            chk("rr_push", 32'(push_out), 32'h1);
            chk("rr_dest", 32'(dest_out), 32'(i % 4));
            chk("rr_data", 32'(data_out), 32'(8'hA0 + (i % 4)));
        end
        chk("rr_wc5", 32'(word_count), 32'd5);
        fifo_empty = 4'hF;
        #1;
        chk("rr_stop_pop", 32'(pop), 32'h0);
        chk("rr_idle", 32'(idle_out), 32'h1);

        // Skip empties: ptr is 1 here
        fifo_empty = 4'b0110;
        #1;
        chk("skip_pop3", 32'(pop), 32'b1000);
        @(posedge clk);
        #1;
        chk("skip_dest", 32'(dest_out), 32'd3);
        chk("skip_data", 32'(data_out), 32'hA3);
        chk("skip_pop0", 32'(pop), 32'b0001);
        fifo_empty = 4'hF;
        @(posedge clk);
        #1;
        chk("skip_wc", 32'(word_count), 32'd6);
        chk("skip_nopush", 32'(push_out), 32'h0);

        // Pause during cycles 3..6; PAUSE exits at end of 7
        exp_pop  = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0,
                     4'h0, 4'h0, 4'h8, 4'h1, 4'h2};
        exp_push = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        fifo_empty = 4'h0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 11; c++) begin
            pause_in = (c >= 3 && c <= 6);
            #1;
            chk($sformatf("pz_pop%0d", c), 32'(pop), 32'(exp_pop[c]));
            chk($sformatf("pz_push%0d", c), 32'(push_out),
                32'(exp_push[c]));
            @(posedge clk);
            #1;
        end
        chk("pz_wc", 32'(word_count), 32'd6);
        chk("pz_dest", 32'(dest_out), 32'd1);

        // Pop/valid mismatch
        do_reset();
        fifo_empty = 4'b1011;
        @(posedge clk);
        #1;
        vforce = 1'b1;
        vovr   = 4'h0;
        #1;
        chk("mm_pop", 32'(pop), 32'b0100);
        @(posedge clk);
        #1;
        vforce     = 1'b0;
        fifo_empty = 4'h0;
        #1;
        chk("mm_err", 32'(error_out), 32'h1);
        chk("mm_pop_off", 32'(pop), 32'h0);
        chk("mm_push", 32'(push_out), 32'h0);
        @(posedge clk);
        #1;
        chk("mm_sticky", 32'(error_out), 32'h1);
        chk("mm_wc", 32'(word_count), 32'h0);
        reset = 1'b0;
        #1;
        chk("mm_rst_err", 32'(error_out), 32'h0);
        chk("mm_rst_idle", 32'(idle_out), 32'h0);
        chk("mm_rst_pop", 32'(pop), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mm_back_pop", 32'(pop), 32'b0001);

        // FIFO error mid-stream discards the word and freezes the count
        do_reset();
        fifo_empty = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("fe_wc2", 32'(word_count), 32'd2);
        fifo_error = 4'b0010;
        #1;
        chk("fe_pop", 32'(pop), 32'b0100);
        @(posedge clk);
        #1;
        fifo_error = 4'h0;
        chk("fe_err", 32'(error_out), 32'h1);
        chk("fe_push", 32'(push_out), 32'h0);
        chk("fe_wc", 32'(word_count), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("fe_sticky", 32'(error_out), 32'h1);
        chk("fe_wc_frz", 32'(word_count), 32'd2);
        chk("fe_pop_off", 32'(pop), 32'h0);

        // Async reset mid-stream
        do_reset();
        fifo_empty = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("ar_push_pre", 32'(push_out), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_push", 32'(push_out), 32'h0);
        chk("ar_data", 32'(data_out), 32'h0);
        chk("ar_dest", 32'(dest_out), 32'h0);
        chk("ar_wc", 32'(word_count), 32'h0);
        chk("ar_pop", 32'(pop), 32'h0);
        @(posedge clk);
        #1;
        chk("ar_push_hold", 32'(push_out), 32'h0);

        // Counter wrap
        do_reset();
        fifo_empty = 4'h0;
        @(posedge clk);
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_max", 32'(word_count), 32'hFFFF);
        @(posedge clk);
        #1;
        chk("wrap_zero", 32'(word_count), 32'h0);
        chk("wrap_push", 32'(push_out), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_fifo_reader.md
# rr_fifo_reader

Round-robin pop-side reader for four input FIFOs of the flow-controlled FIFO type. It pops one word per cycle from the next non-empty FIFO and forwards it, with its source index, as a registered push toward a downstream FIFO. Pops stop while the downstream FIFO reports almost-full (pause). The block goes to a sticky error state on any FIFO error or pop/valid mismatch.

## Interface
- `DW`, 8: data width of every FIFO word.
- `CW`, 16: width of the forwarded-word counter.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  4  per-FIFO empty flag, bit i = FIFO i.
- `fifo_valid`  in  4  per-FIFO valid_out; combinational response to `pop` in the same cycle.
- `fifo_error`  in  4  per-FIFO error flag.
- `data_in0`..`data_in3`  in  DW each  FIFO data outputs, valid when the matching `fifo_valid` bit is 1.
- `pause_in`  in  1  downstream almost-full; 1 = do not pop.
- `pop`  out  4  one-hot (or zero) pop request, combinational.
- `data_out`  out  DW  forwarded word, registered.
- `push_out`  out  1  push to downstream, registered.
- `dest_out`  out  2  source FIFO index of `data_out`, registered.
- `error_out`  out  1  1 while in ERROR.
- `idle_out`  out  1  1 when in ACTIVE and all four `fifo_empty` bits are 1.
- `word_count`  out  CW  words forwarded since reset; wraps modulo 2^CW.

## Operation
- FSM states: IDLE, ACTIVE, PAUSE, ERROR. State is held in a register.
- IDLE → ACTIVE on the first clock edge after `reset` is released.
- ACTIVE → PAUSE when `pause_in` = 1 at the edge.
- PAUSE → ACTIVE when `pause_in` = 0 at the edge.
- Any state except IDLE → ERROR when a fault is seen at the edge. ERROR has priority over all other transitions. Faults:
  - any `fifo_error` bit = 1;
  - `pop[i]` = 1 and `fifo_valid[i]` = 0;
  - `fifo_valid[j]` = 1 and `pop[j]` = 0.
- ERROR is sticky. Only `reset` leaves it.
- Grant: a 2-bit register `ptr` (reset 0) marks the highest-priority FIFO. The search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first FIFO with `fifo_empty` = 0 is granted.
- `pop` = grant when state = ACTIVE and `pause_in` = 0; otherwise `pop` = 0.
  - `pop` is combinational on `pause_in` and `fifo_empty`, so a FIFO holding one entry is never popped twice.
- When a pop occurs, `ptr` ← granted index + 1 (mod 4). With no pop, `ptr` holds.
- Capture: when `fifo_valid[i]` = 1 at an edge (with no fault):
  - `data_out` ← `data_in`i;
  - `dest_out` ← i;
  - `push_out` ← 1;
  - `word_count` ← `word_count` + 1.
- Otherwise `push_out` ← 0, and `data_out`/`dest_out` hold their last value.
- On entry to ERROR, `push_out` ← 0, and the word that caused the fault is discarded.

## Timing
- Reset values: state IDLE, `ptr` 0, `data_out` 0, `push_out` 0, `dest_out` 0, `word_count` 0, `error_out` 0. Hence `pop` = 0 and `idle_out` = 0 during reset.
- Asserting `reset` mid-operation clears everything immediately and drops any in-flight word.
- Latency: pop in cycle T → `push_out` = 1 with the data in cycle T+1.
- Throughput: one word per cycle in steady state.
- Pause:
  - `pause_in` rising in cycle T suppresses `pop` in T itself.
  - A word popped in T-1 is still pushed in T, so the downstream almost-full threshold must leave at least one free slot.
  - After `pause_in` falls in cycle T, `pop` resumes in T+1, because PAUSE exits at the end-of-T edge.
- IDLE lasts exactly one cycle after reset release. No pops occur in IDLE.
- `error_out` rises one cycle after the faulting cycle.
- `word_count` wraps from 2^CW−1 to 0 with no flag.

## Test plan
- Round robin: reset; `fifo_empty` = 4'b0000; valid loopback from `pop`; data_in*i* = 8'hA0+i → `pop` cycles 0001, 0010, 0100, 1000, 0001; `push_out` = 1 from the cycle after the first pop; `dest_out` sequence 0, 1, 2, 3, 0; `word_count` = 5 after 5 words.
- Skipping empties: `ptr` = 1, `fifo_empty` = 4'b0110 → `pop` = 4'b1000, then `ptr` = 0; next cycle `pop` = 4'b0001.
- Pause: pause_in = 1 for cycles 3–6 → `pop` = 0 in cycles 3–6 and 7 (PAUSE exits at end of 7); one trailing `push_out` in cycle 3; pops resume in cycle 8 at the saved `ptr`.
- Pop/valid mismatch: force `fifo_valid` = 0 while `pop` = 4'b0100 → `error_out` = 1 next cycle; `pop` = 0 and `push_out` = 0 thereafter; pulsing `reset` low restores IDLE with all outputs 0.
- FIFO error: `fifo_error` = 4'b0010 for one cycle mid-stream → ERROR is sticky; `word_count` is frozen.
- Async reset mid-stream: drop `reset` between edges → outputs go to reset values immediately, with no further push. Separately, preload `word_count` to 16'hFFFF via 65535 transfers and do one more → `word_count` = 0.
